leg_stack_ctrl: RTL and testbench
=================================

// Module: leg_stack_ctrl
// PURPOSE
//  Call/return and data-stack sequencer for the LEG callret CPU.
//  - Owns the stack pointer.
//  - Shares the single-port 256x8 data RAM between the datapath load/store path and stack push/pop/call/ret.
//  - Stalls the program counter while a pop or return read is in flight.
//  - Supplies the return address to the PC counter's load input.
// PARAMETERS
//  DATA_W      8      RAM word and data width
//  ADDR_W      8      RAM address width
//  STACK_BASE  8'hFF  highest stack address; the stack grows down
//  STACK_DEPTH 16     maximum number of entries (1..2^ADDR_W)
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous, active-low reset
//  call_req      in   1       CALL: push ret_addr_in
//  ret_req       in   1       RET: pop into PC
//  push_req      in   1       PUSH push_data
//  pop_req       in   1       POP into pop_data
//  ret_addr_in   in   ADDR_W  return address (PC+4)
//  push_data     in   DATA_W  push operand
//  flag_clr      in   1       clear sticky error flags
//  cpu_req       in   1       datapath RAM access request
//  cpu_we        in   1       datapath write enable
//  cpu_addr      in   ADDR_W  datapath address
//  cpu_wdata     in   DATA_W  datapath write data
//  cpu_gnt       out  1       datapath access performed this cycle
//  cpu_rdata     out  DATA_W  RAM read data, passed through
//  ram_addr      out  ADDR_W  RAM address
//  ram_we        out  1       RAM write enable
//  ram_re        out  1       RAM read enable; data is returned the next cycle
//  ram_wdata     out  DATA_W  RAM write data
//  ram_rdata     in   DATA_W  RAM read data
//  stall         out  1       hold the PC counter
//  pc_load       out  1       load pc_value into the PC, one-cycle pulse
//  pc_value      out  ADDR_W  popped return address
//  pop_valid     out  1       pop_data valid, one-cycle pulse
//  pop_data      out  DATA_W  popped value
//  sp            out  ADDR_W  current stack pointer (top entry)
//  overflow      out  1       sticky error flag
//  underflow     out  1       sticky error flag
// BEHAVIOUR
//  Reset values
//   - sp = STACK_BASE+1 (mod 2^ADDR_W), depth = 0, state IDLE.
//   - All other outputs 0.
//  States
//   - IDLE: accept one request per cycle.
//   - POP_WAIT: one cycle; capture ram_rdata; return to IDLE.
//  Request priority
//   - call > ret > push > pop.
//   - Lower-priority requests in the same cycle are dropped.
//   - Any stack request beats cpu_req: cpu_gnt=0 that cycle; the datapath retries.
//  Push or call (IDLE)
//   - Same cycle: ram_we=1, ram_addr=sp-1, ram_wdata = ret_addr_in or push_data.
//   - At the clock edge: sp decrements, depth increments.
//   - No stall.
//  Pop or ret (IDLE)
//   - Cycle 0: ram_re=1, ram_addr=sp, stall=1; go to POP_WAIT.
//   - Cycle 1: ret gives pc_load=1, pc_value=ram_rdata; pop gives pop_valid=1, pop_data=ram_rdata.
//   - Cycle 1: sp increments, depth decrements; stall=0.
//  POP_WAIT
//   - All stack requests are ignored, not queued.
//   - The RAM port is free, so cpu_req is granted.
//  Datapath access (IDLE, no stack request)
//   - cpu_gnt = cpu_req; ram_* = cpu_*; cpu_rdata follows the RAM's one-cycle read latency.
//  Address arithmetic is modulo 2^ADDR_W; depth is held separately, 0..STACK_DEPTH.
//  Boundaries (LEG_STACK_BOUNDS_EN)
//   - Push or call with depth==STACK_DEPTH: no write, sp unchanged, overflow<=1.
//   - Pop or ret with depth==0: no RAM read, no stall, sp unchanged, underflow<=1.
//     The next cycle still pulses pop_valid or pc_load, with value 0.
//   - flag_clr clears both flags; a new error in the same cycle wins (flag=1).
//  Reset asserted mid-POP_WAIT: abort immediately, no pc_load or pop_valid pulse.
// CONFIGURATION
//  LEG_STACK_BOUNDS_EN
//   - Defined: depth tracking, overflow/underflow detection and suppression as above.
//   - Undefined: no depth register; sp wraps freely; overflow=underflow=0; flag_clr is ignored.
// STRUCTURE
//  Package leg_stack_pkg holds:
//   - state enum {IDLE, POP_WAIT};
//   - op enum {OP_NONE, OP_CALL, OP_RET, OP_PUSH, OP_POP} and the priority-encode function;
//   - the default STACK_BASE constant.
//  Sub-module leg_stack_ptr holds sp/depth, inc/dec and full/empty flags.
// TESTING
//  1. Reset release: sp=0x00, all outputs 0; cpu_req write 0x10<-0xAB gives cpu_gnt=1, RAM[0x10]=0xAB.
//  2. call ret_addr_in=0x24 -> RAM[0xFF]=0x24, sp=0xFF.
//     Then ret -> stall one cycle, then pc_load=1, pc_value=0x24, sp=0x00.
//  3. push 0x11, push 0x22, pop, pop -> pop_data 0x22 then 0x11, pop_valid pulses, final sp=0x00.
//  4. call + cpu_req in the same cycle -> cpu_gnt=0, call performed.
//     cpu_req held -> granted the next cycle.
//  5. Bounds on, 16 pushes then a 17th -> overflow=1, sp=0xF0, RAM[0xEF] untouched.
//     flag_clr -> overflow=0.
//  6. Bounds on, pop when empty -> underflow=1, pop_valid with 0x00, no stall.
//     rst low during POP_WAIT -> no pulse, sp=0x00.

Source files
------------

// File: rtl/leg_stack_pkg.sv
// leg_stack_pkg: shared state/op types, request priority encoder and default stack base for leg_stack_ctrl
package leg_stack_pkg;
  localparam logic [7:0] STACK_BASE_DEF = 8'hFF;
  typedef enum logic {IDLE, POP_WAIT} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_CALL, OP_RET, OP_PUSH, OP_POP} op_t;
  function automatic op_t prio_op(input logic call, input logic ret, input logic push, input logic pop);
    return call ? OP_CALL : ret ? OP_RET : push ? OP_PUSH : pop ? OP_POP : OP_NONE;
  endfunction
endpackage

// File: rtl/leg_stack_ptr.sv
// leg_stack_ptr: stack pointer with optional depth tracking and full/empty flags (LEG_STACK_BOUNDS_EN)
module leg_stack_ptr
  import leg_stack_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE = ADDR_W'(STACK_BASE_DEF),
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) sp <= STACK_BASE + 1'b1;
    else if (push) sp <= sp - 1'b1;
    else if (pop) sp <= sp + 1'b1;
`ifdef LEG_STACK_BOUNDS_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);
  logic [DW-1:0] depth;
  always_ff @(posedge clk or negedge rst)
    if (!rst) depth <= '0;
    else if (push) depth <= depth + 1'b1;
    else if (pop) depth <= depth - 1'b1;
  assign full  = depth == DW'(STACK_DEPTH);
  assign empty = depth == '0;
`else
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif
endmodule

// File: rtl/leg_stack_ctrl.sv
// leg_stack_ctrl: call/return and data-stack sequencer sharing one RAM port with the datapath.
// Bounds checking and sticky overflow/underflow flags are enabled by LEG_STACK_BOUNDS_EN.
module leg_stack_ctrl
  import leg_stack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE = ADDR_W'(STACK_BASE_DEF),
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [ADDR_W-1:0] ret_addr_in,
  input  logic [DATA_W-1:0] push_data,
  input  logic              flag_clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W-1:0] sp,
  output logic              overflow,
  output logic              underflow
);
  state_t state, state_nxt;
  op_t op;
  logic pend_ret, pend_empty, sp_dec, sp_inc, full, empty, ovf_set, unf_set, wr_op, rd_op;
  leg_stack_ptr #(.ADDR_W(ADDR_W), .STACK_BASE(STACK_BASE), .STACK_DEPTH(STACK_DEPTH)) u_ptr (
    .clk(clk), .rst(rst), .push(sp_dec), .pop(sp_inc), .sp(sp), .full(full), .empty(empty)
  );
  assign cpu_rdata = ram_rdata;
  always_comb begin
    op = state == IDLE ? prio_op(call_req, ret_req, push_req, pop_req) : OP_NONE;
    wr_op = op == OP_CALL || op == OP_PUSH;
    rd_op = op == OP_RET || op == OP_POP;
    cpu_gnt = 1'b0;
    ram_we = 1'b0;
    ram_re = 1'b0;
    ram_addr = '0;
    ram_wdata = '0;
    stall = 1'b0;
    sp_dec = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    state_nxt = rd_op ? POP_WAIT : IDLE;
    if (wr_op) begin
      ram_we = !full;
      ram_addr = full ? '0 : sp - 1'b1;
      ram_wdata = full ? '0 : op == OP_CALL ? DATA_W'(ret_addr_in) : push_data;
      sp_dec = !full;
      ovf_set = full;
    end else if (rd_op) begin
      ram_re = !empty;
      ram_addr = empty ? '0 : sp;
      stall = !empty;
      unf_set = empty;
    end else begin
      cpu_gnt = cpu_req;
      ram_we = cpu_req && cpu_we;
      ram_re = cpu_req && !cpu_we;
      ram_addr = cpu_req ? cpu_addr : '0;
      ram_wdata = cpu_req && cpu_we ? cpu_wdata : '0;
    end
  end
  // the pop/ret result is consumed combinationally in POP_WAIT, so an async reset kills the pulse
  assign sp_inc    = state == POP_WAIT && !pend_empty;
  assign pc_load   = state == POP_WAIT && pend_ret;
  assign pop_valid = state == POP_WAIT && !pend_ret;
  assign pc_value  = pc_load && !pend_empty ? ADDR_W'(ram_rdata) : '0;
  assign pop_data  = pop_valid && !pend_empty ? ram_rdata : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pend_ret <= 1'b0;
      pend_empty <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_op) begin
        pend_ret <= op == OP_RET;
        pend_empty <= empty;
      end
    end
`ifdef LEG_STACK_BOUNDS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= ovf_set || (overflow && !flag_clr);
      underflow <= unf_set || (underflow && !flag_clr);
    end
`else
  logic unused_flags;
  assign unused_flags = ^{flag_clr, ovf_set, unf_set};
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_leg_stack_ctrl.sv
// tb_leg_stack_ctrl: directed self-checking bench for leg_stack_ctrl with a behavioural 256x8 RAM
module tb_leg_stack_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic call_req, ret_req, push_req, pop_req, flag_clr, cpu_req, cpu_we;
  logic [7:0] ret_addr_in, push_data, cpu_addr, cpu_wdata;
  logic cpu_gnt, ram_we, ram_re, stall, pc_load, pop_valid, overflow, underflow;
  logic [7:0] cpu_rdata, ram_addr, ram_wdata, ram_rdata, pc_value, pop_data, sp;
  logic [7:0] mem [256];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  leg_stack_ctrl dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req), .push_req(push_req),
    .pop_req(pop_req), .ret_addr_in(ret_addr_in), .push_data(push_data), .flag_clr(flag_clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_re(ram_re), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall(stall),
    .pc_load(pc_load), .pc_value(pc_value), .pop_valid(pop_valid), .pop_data(pop_data),
    .sp(sp), .overflow(overflow), .underflow(underflow)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic clear_in();
    {call_req, ret_req, push_req, pop_req, flag_clr, cpu_req, cpu_we} = '0;
    {ret_addr_in, push_data, cpu_addr, cpu_wdata} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b0;
    repeat (2) step();
    n_chk++; if (sp !== 8'h00) begin n_fail++; $display("FAIL reset_sp got=%h exp=00", sp); end
    n_chk++;
    if ({cpu_gnt, ram_we, ram_re, stall, pc_load, pop_valid, overflow, underflow} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000000",
        {cpu_gnt, ram_we, ram_re, stall, pc_load, pop_valid, overflow, underflow});
    end
    n_chk++;
    if ({ram_addr, ram_wdata, pc_value, pop_data} !== 32'h0) begin
      n_fail++; $display("FAIL reset_buses got=%h exp=0", {ram_addr, ram_wdata, pc_value, pop_data});
    end
    rst = 1'b1;
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hAB;
    #1;
    n_chk++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_gnt got=%b exp=1", cpu_gnt); end
    n_chk++; if (ram_addr !== 8'h10) begin n_fail++; $display("FAIL cpu_wr_addr got=%h exp=10", ram_addr); end
    step();
    clear_in();
    n_chk++; if (mem[8'h10] !== 8'hAB) begin n_fail++; $display("FAIL cpu_wr_mem got=%h exp=ab", mem[8'h10]); end
  endtask

  task automatic test_call_ret();
    call_req = 1; ret_addr_in = 8'h24;
    #1;
    n_chk++;
    if ({ram_we, ram_addr, ram_wdata, stall} !== {1'b1, 8'hFF, 8'h24, 1'b0}) begin
      n_fail++; $display("FAIL call_port got we=%b addr=%h wd=%h stall=%b exp 1 ff 24 0", ram_we, ram_addr, ram_wdata, stall);
    end
    step();
    clear_in();
    n_chk++; if (mem[8'hFF] !== 8'h24) begin n_fail++; $display("FAIL call_mem got=%h exp=24", mem[8'hFF]); end
    n_chk++; if (sp !== 8'hFF) begin n_fail++; $display("FAIL call_sp got=%h exp=ff", sp); end
    ret_req = 1;
    #1;
    n_chk++;
    if ({stall, ram_re, ram_addr} !== {1'b1, 1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL ret_cyc0 got stall=%b re=%b addr=%h exp 1 1 ff", stall, ram_re, ram_addr);
    end
    step();
    ret_req = 0;
    n_chk++;
    if ({pc_load, pc_value, stall} !== {1'b1, 8'h24, 1'b0}) begin
      n_fail++; $display("FAIL ret_cyc1 got load=%b pc=%h stall=%b exp 1 24 0", pc_load, pc_value, stall);
    end
    step();
    n_chk++; if (sp !== 8'h00) begin n_fail++; $display("FAIL ret_sp got=%h exp=00", sp); end
    n_chk++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL ret_pulse got=%b exp=0", pc_load); end
  endtask

  task automatic test_push_pop();
    logic [7:0] vals [2] = '{8'h11, 8'h22};
    for (int i = 0; i < 2; i++) begin
      push_req = 1; push_data = vals[i];
      step();
    end
    clear_in();
    n_chk++; if (sp !== 8'hFE) begin n_fail++; $display("FAIL push_sp got=%h exp=fe", sp); end
    for (int i = 1; i >= 0; i--) begin
      pop_req = 1;
      step();
      pop_req = 0;
      n_chk++;
      if ({pop_valid, pop_data} !== {1'b1, vals[i]}) begin
        n_fail++; $display("FAIL pop_%0d got v=%b d=%h exp 1 %h", i, pop_valid, pop_data, vals[i]);
      end
      step();
      n_chk++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL pop_pulse_%0d got=%b exp=0", i, pop_valid); end
    end
    n_chk++; if (sp !== 8'h00) begin n_fail++; $display("FAIL pop_sp got=%h exp=00", sp); end
  endtask

  task automatic test_arbitration();
    call_req = 1; ret_addr_in = 8'h30;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h55;
    #1;
    n_chk++;
    if ({cpu_gnt, ram_addr, ram_wdata} !== {1'b0, 8'hFF, 8'h30}) begin
      n_fail++; $display("FAIL arb_call got gnt=%b addr=%h wd=%h exp 0 ff 30", cpu_gnt, ram_addr, ram_wdata);
    end
    step();
    call_req = 0;
    #1;
    n_chk++;
    if ({cpu_gnt, ram_addr} !== {1'b1, 8'h40}) begin
      n_fail++; $display("FAIL arb_retry got gnt=%b addr=%h exp 1 40", cpu_gnt, ram_addr);
    end
    step();
    clear_in();
    n_chk++; if (mem[8'h40] !== 8'h55) begin n_fail++; $display("FAIL arb_mem got=%h exp=55", mem[8'h40]); end
    ret_req = 1;
    step();
    ret_req = 0; cpu_req = 1; cpu_addr = 8'h40;
    #1;
    n_chk++;
    if ({cpu_gnt, pc_load, pc_value} !== {1'b1, 1'b1, 8'h30}) begin
      n_fail++; $display("FAIL popwait_cpu got gnt=%b load=%b pc=%h exp 1 1 30", cpu_gnt, pc_load, pc_value);
    end
    step();
    clear_in();
    n_chk++; if (cpu_rdata !== 8'h55) begin n_fail++; $display("FAIL cpu_rdata got=%h exp=55", cpu_rdata); end
    n_chk++; if (sp !== 8'h00) begin n_fail++; $display("FAIL arb_sp got=%h exp=00", sp); end
  endtask

  task automatic test_priority();
    push_req = 1; pop_req = 1; push_data = 8'h5A;
    #1;
    n_chk++;
    if ({ram_we, ram_re, ram_wdata} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL prio_push got we=%b re=%b wd=%h exp 1 0 5a", ram_we, ram_re, ram_wdata);
    end
    step();
    ret_req = 1;
    #1;
    n_chk++;
    if ({ram_re, ram_we, stall} !== 3'b101) begin
      n_fail++; $display("FAIL prio_ret got re=%b we=%b stall=%b exp 1 0 1", ram_re, ram_we, stall);
    end
    step();
    clear_in();
    push_req = 1; push_data = 8'hEE;
    #1;
    n_chk++;
    if ({ram_we, pc_load, pop_valid, pc_value} !== {1'b0, 1'b1, 1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL popwait_ignore got we=%b load=%b pv=%b pc=%h exp 0 1 0 5a", ram_we, pc_load, pop_valid, pc_value);
    end
    step();
    clear_in();
    n_chk++; if (sp !== 8'h00) begin n_fail++; $display("FAIL prio_sp got=%h exp=00", sp); end
  endtask

`ifdef LEG_STACK_BOUNDS_EN
  task automatic test_bounds();
    for (int i = 0; i < 16; i++) begin
      push_req = 1; push_data = 8'(i + 1);
      step();
    end
    n_chk++;
    if ({sp, overflow} !== {8'hF0, 1'b0}) begin
      n_fail++; $display("FAIL full_state got sp=%h ovf=%b exp f0 0", sp, overflow);
    end
    push_data = 8'h99;
    #1;
    n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL ovf_we got=%b exp=0", ram_we); end
    step();
    clear_in();
    n_chk++;
    if ({overflow, sp, mem[8'hEF]} !== {1'b1, 8'hF0, 8'h00}) begin
      n_fail++; $display("FAIL ovf got ovf=%b sp=%h mem=%h exp 1 f0 00", overflow, sp, mem[8'hEF]);
    end
    flag_clr = 1;
    step();
    flag_clr = 0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    rst = 0;
    step();
    rst = 1;
    step();
    pop_req = 1;
    #1;
    n_chk++;
    if ({stall, ram_re} !== 2'b00) begin
      n_fail++; $display("FAIL unf_cyc0 got stall=%b re=%b exp 0 0", stall, ram_re);
    end
    step();
    pop_req = 0;
    n_chk++;
    if ({underflow, pop_valid, pop_data, sp} !== {1'b1, 1'b1, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL unf got unf=%b pv=%b d=%h sp=%h exp 1 1 00 00", underflow, pop_valid, pop_data, sp);
    end
    step();
    pop_req = 1; flag_clr = 1;
    step();
    clear_in();
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_clr_race got=%b exp=1", underflow); end
    step();
    flag_clr = 1;
    step();
    flag_clr = 0;
    n_chk++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr got=%b exp=0", underflow); end
  endtask
`else
  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      push_req = 1; push_data = 8'(i + 1);
      step();
    end
    clear_in();
    n_chk++;
    if ({sp, overflow, mem[8'hEF]} !== {8'hEF, 1'b0, 8'h11}) begin
      n_fail++; $display("FAIL wrap got sp=%h ovf=%b mem=%h exp ef 0 11", sp, overflow, mem[8'hEF]);
    end
    rst = 0;
    step();
    rst = 1;
    step();
    pop_req = 1;
    #1;
    n_chk++;
    if ({stall, ram_re, ram_addr} !== {1'b1, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL wrap_pop got stall=%b re=%b addr=%h exp 1 1 00", stall, ram_re, ram_addr);
    end
    step();
    pop_req = 0;
    step();
    n_chk++;
    if ({sp, underflow} !== {8'h01, 1'b0}) begin
      n_fail++; $display("FAIL wrap_sp got sp=%h unf=%b exp 01 0", sp, underflow);
    end
    rst = 0;
    step();
    rst = 1;
    step();
  endtask
`endif

  task automatic test_reset_abort();
    push_req = 1; push_data = 8'h77;
    step();
    clear_in();
    pop_req = 1;
    @(posedge clk);
    rst = 0; pop_req = 0;
    #1;
    n_chk++;
    if ({pop_valid, pc_load, sp} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL abort got pv=%b load=%b sp=%h exp 0 0 00", pop_valid, pc_load, sp);
    end
    step();
    rst = 1;
    step();
    n_chk++;
    if ({pop_valid, pc_load, sp} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL abort_after got pv=%b load=%b sp=%h exp 0 0 00", pop_valid, pc_load, sp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_rdata = 8'h00;
    test_reset();
    test_call_ret();
    test_push_pop();
    test_arbitration();
    test_priority();
`ifdef LEG_STACK_BOUNDS_EN
    test_bounds();
`else
    test_wrap();
`endif
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
